// File: rtl/mainfsm.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/execute/writeback.
// Optional macro MAINFSM_ILLEGAL_TRAP_EN traps unsupported opcodes in a sticky ERROR state.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    ERROR    = 4'd11
  } statetype;

  localparam logic [6:0] OPLW   = 7'b0000011;
  localparam logic [6:0] OPSW   = 7'b0100011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] OPI    = 7'b0010011;
  localparam logic [6:0] OPJAL  = 7'b1101111;
  localparam logic [6:0] OPBEQ  = 7'b1100011;

  statetype statereg, nextstate, outstate;
  logic     branch, pcupdate;
  logic     irwrite_s, regwrite_s, memwrite_s;

  always_ff @(posedge clk) begin
    if (reset) statereg <= FETCH;
    else       statereg <= nextstate;
  end

  always_comb begin
    nextstate = FETCH;
    case (statereg)
      FETCH:    nextstate = DECODE;
      DECODE: begin
        case (op)
          OPLW, OPSW: nextstate = MEMADR;
          OPR:        nextstate = EXECUTER;
          OPI:        nextstate = EXECUTEI;
          OPJAL:      nextstate = JAL;
          OPBEQ:      nextstate = BEQ;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
          default:    nextstate = ERROR;
`else
          default:    nextstate = FETCH;
`endif
        endcase
      end
      MEMADR:   nextstate = (op == OPSW) ? MEMWRITE : MEMREAD;
      MEMREAD:  nextstate = MEMWB;
      MEMWB:    nextstate = FETCH;
      MEMWRITE: nextstate = FETCH;
      EXECUTER: nextstate = ALUWB;
      EXECUTEI: nextstate = ALUWB;
      JAL:      nextstate = ALUWB;
      ALUWB:    nextstate = FETCH;
      BEQ:      nextstate = FETCH;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
      ERROR:    nextstate = ERROR;
`endif
      default:  nextstate = FETCH;
    endcase
  end

  // During reset the datapath sees FETCH selects, but every write enable is suppressed.
  assign outstate = reset ? FETCH : statereg;

  always_comb begin
    AdrSrc     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    regwrite_s = 1'b0;
    branch     = 1'b0;
    pcupdate   = 1'b0;
    illegal    = 1'b0;
    case (outstate)
      FETCH: begin
        irwrite_s = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pcupdate  = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_s = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      ALUWB:    regwrite_s = 1'b1;
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
`ifdef MAINFSM_ILLEGAL_TRAP_EN
      ERROR:    illegal = 1'b1;
`endif
      default: ;
    endcase
  end

  assign PCWrite  = ~reset & ((branch & zero) | pcupdate);
  assign IRWrite  = ~reset & irwrite_s;
  assign RegWrite = ~reset & regwrite_s;
  assign MemWrite = ~reset & memwrite_s;
  assign state    = statereg;

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: directed instruction sequences plus random
// instruction streams checked against per-instruction state paths.
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit isLegal(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_JAL) || (o == OP_BEQ);
  endfunction

  // Expected {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,RegWrite,illegal}.
  function automatic logic [15:0] expVec(input int s, input logic z, input bit rst);
    logic       pcw, adr, mw, irw, rw, ill, br, pcu;
    logic [1:0] res, sa, sb, aop;
    int         st;
    st = rst ? 0 : s;
    {pcw, adr, mw, irw, rw, ill, br, pcu} = '0;
    {res, sa, sb, aop} = '0;
    case (st)
      0:  begin irw = 1; sb = 2'b10; res = 2'b10; pcu = 1; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1;
      4:  begin res = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2'b10; aop = 2'b10; end
      7:  rw = 1;
      8:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      9:  begin sa = 2'b01; sb = 2'b10; pcu = 1; end
      10: begin sa = 2'b10; aop = 2'b01; br = 1; end
      11: ill = 1;
      default: ;
    endcase
    pcw = (br & z) | pcu;
    if (rst) begin
      pcw = 0; irw = 0; rw = 0; mw = 0;
    end
    return {pcw, adr, mw, irw, res, sa, sb, aop, rw, ill};
  endfunction

  task automatic checkOutput(input int expState, input bit rst, input bit chkState);
    logic [15:0] got, want;
    got  = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
            RegWrite, illegal};
    want = expVec(expState, zero, rst);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL outputs st=%0d rst=%0d got=%b want=%b", expState, rst, got, want);
    end
    if (chkState) begin
      vectors++;
      assert (state === 4'(expState)) else begin
        miscompares++;
        $error("[TB] FAIL state got=%0d want=%0d", state, expState);
      end
    end
  endtask

  // Runs one instruction from FETCH; zmode 0/1 forces zero, 2 randomizes it.
  // stopAt>0 truncates the walk after that many cycles.
  task automatic applyStimulus(input logic [6:0] opc, input int zmode, input int stopAt);
    int p[$];
    int n;
    p.push_back(0);
    p.push_back(1);
    case (opc)
      OP_LW:  begin p.push_back(2); p.push_back(3); p.push_back(4); end
      OP_SW:  begin p.push_back(2); p.push_back(5); end
      OP_R:   begin p.push_back(6); p.push_back(7); end
      OP_I:   begin p.push_back(8); p.push_back(7); end
      OP_JAL: begin p.push_back(9); p.push_back(7); end
      OP_BEQ: p.push_back(10);
      default: begin
`ifdef MAINFSM_ILLEGAL_TRAP_EN
        for (int k = 0; k < 10; k++) p.push_back(11);
`endif
      end
    endcase
    n = (stopAt > 0) ? stopAt : p.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op   = (p[i] == 1 || p[i] == 2) ? opc : 7'($urandom);
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1 checkOutput(p[i], 1'b0, 1'b1);
    end
  endtask

  // Asserts reset between edges, checks the forced outputs, releases after a posedge.
  task automatic applyReset();
    reset = 1'b1;
    #1 checkOutput(0, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      zero = 1'($urandom_range(0, 1));
      #1 checkOutput(0, 1'b1, 1'b1);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [6:0] ropc;
    int         k;
    op    = OP_LW;
    zero  = 1'b0;
    applyReset();

    applyStimulus(OP_LW, 2, 0);
    applyStimulus(OP_SW, 2, 0);
    applyStimulus(OP_BEQ, 1, 0);
    applyStimulus(OP_BEQ, 0, 0);
    applyStimulus(OP_R, 2, 0);
    applyStimulus(OP_I, 2, 0);
    applyStimulus(OP_JAL, 2, 0);

    applyStimulus(OP_LW, 2, 4);
    applyReset();
    applyStimulus(OP_LW, 2, 0);

    applyStimulus(7'b1111111, 2, 0);
`ifdef MAINFSM_ILLEGAL_TRAP_EN
    applyReset();
`endif
    applyStimulus(OP_R, 2, 0);

    repeat (60) begin
      k = $urandom_range(0, 6);
      case (k)
        0: ropc = OP_LW;
        1: ropc = OP_SW;
        2: ropc = OP_R;
        3: ropc = OP_I;
        4: ropc = OP_JAL;
        5: ropc = OP_BEQ;
        default: begin
`ifdef MAINFSM_ILLEGAL_TRAP_EN
          ropc = OP_BEQ;
`else
          ropc = 7'($urandom);
          while (isLegal(ropc)) ropc = 7'($urandom);
`endif
        end
      endcase
      applyStimulus(ropc, 2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
